// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: widths and ALU control encodings.
// No logic; constants only.
// Not applicable (package).
package mips_pkg;

  localparam int DW = 32;
  localparam int RW = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: EX/MEM result, else MEM/WB result, else register file.
// Latency: combinational.
// Backpressure: none (pure select).
module fwd_mux #(
  parameter int DW = mips_pkg::DW
) (
  input  logic [4:0]    idx,
  input  logic [DW-1:0] rf_data,
  input  logic          exm_reg_write,
  input  logic [4:0]    exm_rd,
  input  logic [DW-1:0] exm_data,
  input  logic          wb_reg_write,
  input  logic [4:0]    wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] fwd_data
);

  logic exm_hit;
  logic wb_hit;

  // Register 0 is hardwired, so a write to it never forwards.
  assign exm_hit = exm_reg_write && (exm_rd != 5'd0) && (exm_rd == idx);
  assign wb_hit  = wb_reg_write  && (wb_rd  != 5'd0) && (wb_rd  == idx);

  // The younger EX/MEM result wins over MEM/WB.
  always_comb begin
    fwd_data = rf_data;
    if (exm_hit)
      fwd_data = exm_data;
    else if (wb_hit)
      fwd_data = wb_data;
  end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall and WB snooping of held data.
// Latency: one cycle from capture to outputs.
// Backpressure: in_ready low while output is held unaccepted, on a load-use hazard, or in reset.
module idex_stage #(
  parameter int DW = mips_pkg::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [DW-1:0] in_rs_data,
  input  logic [DW-1:0] in_rt_data,
  input  logic [15:0]   in_imm,
  input  logic          in_alusrc,
  input  logic [3:0]    in_aluctr,
  input  logic          in_mem_read,
  input  logic          in_reg_write,
  input  logic          flush,
  input  logic          exm_reg_write,
  input  logic [4:0]    exm_rd,
  input  logic [DW-1:0] exm_data,
  input  logic          wb_reg_write,
  input  logic [4:0]    wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] input1,
  output logic [DW-1:0] input2,
  output logic [3:0]    aluctr,
  output logic [4:0]    out_rd,
  output logic          out_mem_read,
  output logic          out_reg_write,
  output logic [DW-1:0] out_rt_data,
  output logic          load_use_stall
);

  import mips_pkg::*;

  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;
  logic [DW-1:0] imm_ext;
  logic [4:0]    hold_rs;
  logic [4:0]    hold_rt;
  logic          hold_alusrc;
  logic          capture;
  logic          held;
  logic          snoop_rs;
  logic          snoop_rt;

  fwd_mux #(.DW(DW)) u_fwd_rs (
    .idx           (in_rs),
    .rf_data       (in_rs_data),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_data      (exm_data),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .fwd_data      (fwd_rs)
  );

  fwd_mux #(.DW(DW)) u_fwd_rt (
    .idx           (in_rt),
    .rf_data       (in_rt_data),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_data      (exm_data),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .fwd_data      (fwd_rt)
  );

  assign imm_ext = {{(DW-16){in_imm[15]}}, in_imm};

  // A load in EX whose destination is read by the incoming instruction cannot be forwarded yet.
  assign load_use_stall = in_valid && out_valid && out_mem_read && (out_rd != 5'd0)
                          && ((out_rd == in_rs) || (out_rd == in_rt));

  assign in_ready = rst_n && (!out_valid || out_ready) && !load_use_stall;
  assign capture  = in_valid && in_ready && !flush;
  assign held     = out_valid && !out_ready;

  // Only a MEM/WB write can land while held; EX/MEM is stalled behind this stage.
  assign snoop_rs = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == hold_rs);
  assign snoop_rt = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == hold_rt);

  // Pipeline register: reset, flush, capture, drain, or snoop-update of held operands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_reg_write <= 1'b0;
      out_mem_read  <= 1'b0;
      input1        <= '0;
      input2        <= '0;
      out_rt_data   <= '0;
      aluctr        <= 4'b0000;
      out_rd        <= 5'd0;
      hold_rs       <= 5'd0;
      hold_rt       <= 5'd0;
      hold_alusrc   <= 1'b0;
    end else if (flush) begin
      out_valid     <= 1'b0;
      out_reg_write <= 1'b0;
      out_mem_read  <= 1'b0;
    end else if (capture) begin
      out_valid     <= 1'b1;
      out_reg_write <= in_reg_write;
      out_mem_read  <= in_mem_read;
      input1        <= fwd_rs;
      input2        <= in_alusrc ? imm_ext : fwd_rt;
      out_rt_data   <= fwd_rt;
      aluctr        <= in_aluctr;
      out_rd        <= in_rd;
      hold_rs       <= in_rs;
      hold_rt       <= in_rt;
      hold_alusrc   <= in_alusrc;
    end else if (held) begin
      if (snoop_rs)
        input1 <= wb_data;
      if (snoop_rt) begin
        out_rt_data <= wb_data;
        if (!hold_alusrc)
          input2 <= wb_data;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_idex_stage.sv
// Directed bench for idex_stage: reset, forwarding, immediate, load-use, backpressure, flush.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: drives out_ready directly per step.
module tb_idex_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [31:0] in_rs_data, in_rt_data;
  logic [15:0] in_imm;
  logic        in_alusrc;
  logic [3:0]  in_aluctr;
  logic        in_mem_read, in_reg_write;
  logic        flush;
  logic        exm_reg_write;
  logic [4:0]  exm_rd;
  logic [31:0] exm_data;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] input1, input2, out_rt_data;
  logic [3:0]  aluctr;
  logic [4:0]  out_rd;
  logic        out_mem_read, out_reg_write;
  logic        load_use_stall;

  int checks = 0;
  int errors = 0;

  idex_stage #(.DW(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rs          (in_rs),
    .in_rt          (in_rt),
    .in_rd          (in_rd),
    .in_rs_data     (in_rs_data),
    .in_rt_data     (in_rt_data),
    .in_imm         (in_imm),
    .in_alusrc      (in_alusrc),
    .in_aluctr      (in_aluctr),
    .in_mem_read    (in_mem_read),
    .in_reg_write   (in_reg_write),
    .flush          (flush),
    .exm_reg_write  (exm_reg_write),
    .exm_rd         (exm_rd),
    .exm_data       (exm_data),
    .wb_reg_write   (wb_reg_write),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .input1         (input1),
    .input2         (input2),
    .aluctr         (aluctr),
    .out_rd         (out_rd),
    .out_mem_read   (out_mem_read),
    .out_reg_write  (out_reg_write),
    .out_rt_data    (out_rt_data),
    .load_use_stall (load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
    in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0;
    in_rs_data = 32'h0; in_rt_data = 32'h0; in_imm = 16'h0;
    in_alusrc = 1'b0; in_aluctr = 4'h0; in_mem_read = 1'b0; in_reg_write = 1'b0;
    exm_reg_write = 1'b0; exm_rd = 5'd0; exm_data = 32'h0;
    wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;

    // Reset held for two edges with in_valid high
    step(); step();
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_input1", input1, 32'h0);
    check("rst_input2", input2, 32'h0);
    check("rst_rt_data", out_rt_data, 32'h0);
    check("rst_aluctr", {28'b0, aluctr}, 32'h0);
    check("rst_out_rd", {27'b0, out_rd}, 32'h0);
    check("rst_reg_write", {31'b0, out_reg_write}, 32'd0);
    check("rst_mem_read", {31'b0, out_mem_read}, 32'd0);

    // Forwarding priority: EX/MEM over MEM/WB
    rst_n = 1'b1; out_ready = 1'b1;
    in_rs = 5'd5; in_rt = 5'd6; in_rd = 5'd3; in_rs_data = 32'hAA; in_rt_data = 32'hBB;
    in_aluctr = 4'b0010; in_reg_write = 1'b1;
    exm_reg_write = 1'b1; exm_rd = 5'd5; exm_data = 32'h11;
    wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'h22;
    #1;
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("fwd_valid", {31'b0, out_valid}, 32'd1);
    check("fwd_exm_input1", input1, 32'h11);
    check("fwd_input2_rf", input2, 32'hBB);
    check("fwd_aluctr", {28'b0, aluctr}, 32'h2);
    check("fwd_out_rd", {27'b0, out_rd}, 32'd3);
    check("fwd_reg_write", {31'b0, out_reg_write}, 32'd1);

    // Back-to-back capture, EX/MEM disabled via rd=0 -> MEM/WB wins
    exm_rd = 5'd0;
    step();
    check("fwd_wb_input1", input1, 32'h22);
    check("b2b_valid", {31'b0, out_valid}, 32'd1);

    // Immediate operand, rt forwarded from WB, non-standard ALU code
    in_alusrc = 1'b1; in_imm = 16'hFFFE; wb_rd = 5'd6; wb_data = 32'h44; in_aluctr = 4'b1111;
    step();
    check("imm_input2", input2, 32'hFFFFFFFE);
    check("imm_rt_data", out_rt_data, 32'h44);
    check("imm_input1_rf", input1, 32'hAA);
    check("imm_aluctr", {28'b0, aluctr}, 32'hF);

    // Capture a load to r8
    in_alusrc = 1'b0; in_mem_read = 1'b1; in_rd = 5'd8; in_rs = 5'd1; in_rt = 5'd2;
    in_rs_data = 32'h10; in_rt_data = 32'h20; in_aluctr = 4'b0010;
    exm_reg_write = 1'b0; wb_reg_write = 1'b0;
    step();
    check("load_mem_read", {31'b0, out_mem_read}, 32'd1);
    check("load_out_rd", {27'b0, out_rd}, 32'd8);

    // Dependent instruction reads r8 via rt
    out_ready = 1'b0;
    in_mem_read = 1'b0; in_rd = 5'd4; in_rs = 5'd9; in_rt = 5'd8;
    in_rs_data = 32'h66; in_rt_data = 32'h55;
    #1;
    check("lu_stall", {31'b0, load_use_stall}, 32'd1);
    check("lu_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    check("lu_held_rd", {27'b0, out_rd}, 32'd8);
    check("lu_stall_held", {31'b0, load_use_stall}, 32'd1);
    out_ready = 1'b1;
    #1;
    check("lu_stall_ready", {31'b0, load_use_stall}, 32'd1);
    step();
    check("lu_drained", {31'b0, out_valid}, 32'd0);
    check("lu_clear", {31'b0, load_use_stall}, 32'd0);
    check("lu_ready_back", {31'b0, in_ready}, 32'd1);
    step();
    check("lu_capture_valid", {31'b0, out_valid}, 32'd1);
    check("lu_capture_rd", {27'b0, out_rd}, 32'd4);
    check("lu_capture_input2", input2, 32'h55);
    check("lu_capture_mem_read", {31'b0, out_mem_read}, 32'd0);

    // Backpressure: held rs=9 snooped from WB, EX/MEM ignored
    out_ready = 1'b0; in_rd = 5'd7; in_rs = 5'd1; in_rt = 5'd2;
    wb_reg_write = 1'b1; wb_rd = 5'd9; wb_data = 32'h33;
    exm_reg_write = 1'b1; exm_rd = 5'd9; exm_data = 32'h77;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_input1", input1, 32'h33);
      check("bp_out_rd", {27'b0, out_rd}, 32'd4);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end

    // Held rt=8 snoop updates store data and register operand 2
    wb_rd = 5'd8; wb_data = 32'h99; exm_reg_write = 1'b0;
    step();
    check("bp_rt_data", out_rt_data, 32'h99);
    check("bp_input2", input2, 32'h99);
    check("bp_input1_kept", input1, 32'h33);

    // Flush concurrent with a valid capture
    wb_reg_write = 1'b0; out_ready = 1'b1; flush = 1'b1; in_reg_write = 1'b1;
    step();
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("flush_reg_write", {31'b0, out_reg_write}, 32'd0);
    check("flush_mem_read", {31'b0, out_mem_read}, 32'd0);
    flush = 1'b0;
    step();
    check("post_flush_valid", {31'b0, out_valid}, 32'd1);
    check("post_flush_rd", {27'b0, out_rd}, 32'd7);

    // Flush of held data
    out_ready = 1'b0; flush = 1'b1;
    step();
    check("flush_held_valid", {31'b0, out_valid}, 32'd0);
    flush = 1'b0;

    // Register 0 is never forwarded
    out_ready = 1'b1; in_rs = 5'd0; in_rs_data = 32'h5;
    exm_reg_write = 1'b1; exm_rd = 5'd0; exm_data = 32'hDEAD;
    wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'hBEEF;
    step();
    check("r0_input1", input1, 32'h5);

    // Reset mid-operation drops held instruction
    out_ready = 1'b0; exm_reg_write = 1'b0; wb_reg_write = 1'b0;
    step();
    check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    rst_n = 1'b0;
    step();
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_input1", input1, 32'h0);
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    check("after_rst_capture", {31'b0, out_valid}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/idex_stage.md
IDEX_STAGE -- requirements
Module: idex_stage

Interface
REQ-001 Parameter DW, default 32, datapath width; only DW=32 is supported.
REQ-002 clk  in  1  rising-edge clock; single clock domain.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 in_valid  in  1; in_ready  out  1  upstream (decode) handshake.
REQ-005 in_rs, in_rt, in_rd  in  5 each  source/destination register indices.
REQ-006 in_rs_data, in_rt_data  in  32  register-file read data.
REQ-007 in_imm  in  16  immediate; in_alusrc  in  1  (1 = use sign-extended in_imm as operand 2).
REQ-008 in_aluctr  in  4; in_mem_read  in  1; in_reg_write  in  1  decoded controls.
REQ-009 flush  in  1  discard the held and incoming instruction.
REQ-010 exm_reg_write  in  1; exm_rd  in  5; exm_data  in  32  EX/MEM forwarding source.
REQ-011 wb_reg_write  in  1; wb_rd  in  5; wb_data  in  32  MEM/WB forwarding source.
REQ-012 out_valid  out  1; out_ready  in  1  downstream (ALU/EX) handshake.
REQ-013 input1, input2  out  32; aluctr  out  4  registered ALU operands and op code.
REQ-014 out_rd  out  5; out_mem_read, out_reg_write  out  1; out_rt_data  out  32  (store data).
REQ-015 load_use_stall  out  1  hazard indicator.

Function
REQ-016 Capture occurs on a rising edge when in_valid && in_ready && !flush; out_valid is 1 in the next cycle.
REQ-017 in_ready SHALL equal (!out_valid || out_ready) && !load_use_stall, and 0 while rst_n is low.
REQ-018 load_use_stall SHALL be in_valid && out_valid && out_mem_read && out_rd!=0 && (out_rd==in_rs || out_rd==in_rt), combinational.
REQ-019 Forwarded rs value: exm_data if exm_reg_write && exm_rd!=0 && exm_rd==in_rs; else wb_data on the same rule with wb_*; else in_rs_data. EX/MEM has priority.
REQ-020 Forwarded rt value uses the rule of REQ-019 with in_rt/in_rt_data.
REQ-021 input1 SHALL capture forwarded rs; input2 SHALL capture {{16{in_imm[15]}},in_imm} when in_alusrc=1, else forwarded rt; out_rt_data SHALL always capture forwarded rt.
REQ-022 aluctr SHALL pass in_aluctr unmodified, including codes other than 0000/0001/0010/0110/0111.
REQ-023 While out_valid && !out_ready (held), a wb write matching the held rs (nonzero) SHALL update input1, and matching held rt SHALL update out_rt_data and, if held alusrc=0, input2.
REQ-024 out_valid SHALL fall to 0 after a cycle with out_ready=1 and no capture; back-to-back capture with out_ready=1 sustains one instruction per cycle.
REQ-025 flush SHALL, next cycle, force out_valid=0, out_reg_write=0, out_mem_read=0; flush overrides a simultaneous capture and held data.
REQ-026 Register index 0 is never forwarded or snooped; held data is not altered by exm_* inputs.
REQ-027 Latency: capture-to-output exactly one cycle; no combinational path from in_* to out_* data outputs.

Reset
REQ-028 On a clock edge with rst_n=0: out_valid, out_reg_write, out_mem_read = 0; input1, input2, out_rt_data = 0; aluctr = 4'b0000; out_rd and held indices = 0.
REQ-029 Reset mid-operation SHALL drop any held instruction without emitting it; first capture possible on the first edge with rst_n=1.

Structure
REQ-030 A shared package mips_pkg SHALL hold DW, register-index width 5, and the ALU control constants (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111).
REQ-031 One sub-module fwd_mux (combinational 3-way forwarding select per REQ-019) SHALL be instantiated twice (rs, rt).

Verification
REQ-032 Reset: rst_n=0 two cycles, in_valid=1 -> in_ready=0, all outputs 0, out_valid=0.
REQ-033 Forwarding: in_rs=5, exm_rd=5 exm_data=0x11, wb_rd=5 wb_data=0x22, both writes=1 -> input1=0x11; exm_rd=0 -> input1=0x22.
REQ-034 Immediate: in_alusrc=1, in_imm=0xFFFE -> input2=0xFFFFFFFE, out_rt_data=forwarded rt.
REQ-035 Load-use: held out_mem_read=1 out_rd=8, incoming in_rt=8 -> load_use_stall=1, in_ready=0 one cycle; on out_ready=1 it clears and instruction captures next cycle.
REQ-036 Backpressure: out_ready=0 three cycles with wb_rd=held rs, wb_data=0x33 -> out_valid stays 1, input1=0x33, no upstream capture.
REQ-037 Flush: flush=1 concurrent with valid capture -> next cycle out_valid=0, out_reg_write=0.
